// File: rtl/game_sequencer.sv
// Play-flow controller for Frogger: IDLE -> START -> RUNNING, with HIT / LEVEL pauses and OVER.
// Latency: every output is a flop; input effects appear one clock after the sampling edge.
// Backpressure: none; level and pulse inputs are sampled every clock and ignored outside IDLE/RUNNING/OVER rules.
//
// Ports:
//   i_Clk, i_Rst_L         clock and async active-low reset
//   i_Start                all four switches pressed (level)
//   i_Has_Collided         collision level from Collisions
//   i_Level_Up             one-cycle pulse when the frog reaches the top row
//   o_Game_Active          high only while RUNNING (gates frog movement)
//   o_Freeze               high in START/HIT/LEVEL/OVER (halts obstacles)
//   o_Frog_Reset           one-cycle pulse on entry to START/HIT/LEVEL
//   o_Lives, o_Level       lives and level counters
//   o_Game_Over            high in OVER
//   o_State                raw state encoding for debug/LEDs
module game_sequencer #(
    parameter int unsigned c_LIVES_INI   = 3,
    parameter int unsigned c_MAX_LEVEL   = 9,
    parameter int unsigned c_START_DELAY = 25_000_000,
    parameter int unsigned c_HIT_FREEZE  = 12_500_000,
    parameter int unsigned c_LEVEL_PAUSE = 12_500_000,
    parameter int unsigned c_OVER_HOLD   = 50_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic       o_Freeze,
    output logic       o_Frog_Reset,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUNNING = 3'd2,
        S_HIT     = 3'd3,
        S_LEVEL   = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    // Timer load values: a state entered with dwell-1 exits on the cycle the
    // timer reads zero, so it is visible for exactly dwell cycles.
    localparam logic [25:0] START_LOAD = 26'(c_START_DELAY - 1);
    localparam logic [25:0] HIT_LOAD   = 26'(c_HIT_FREEZE - 1);
    localparam logic [25:0] LEVEL_LOAD = 26'(c_LEVEL_PAUSE - 1);
    localparam logic [25:0] OVER_LOAD  = 26'(c_OVER_HOLD - 1);
    localparam logic [1:0]  LIVES_INI  = 2'(c_LIVES_INI);
    localparam logic [3:0]  MAX_LEVEL  = 4'(c_MAX_LEVEL);

    // State register kept as a plain vector so encodings 6/7 are
    // representable and can be recovered from.
    logic [2:0]  state_q;
    state_t      state_d;
    logic [25:0] timer_q, timer_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  level_q, level_d;
    logic        expired;

    logic game_active_q, freeze_q, frog_reset_q, game_over_q;

    assign expired = (timer_q == 26'd0);

    always_comb begin
        state_d = S_IDLE;
        timer_d = expired ? timer_q : timer_q - 26'd1;
        lives_d = lives_q;
        level_d = level_q;

        case (state_q)
            S_IDLE: begin
                lives_d = LIVES_INI;
                level_d = 4'd1;
                if (i_Start) begin
                    state_d = S_START;
                    timer_d = START_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                state_d = expired ? S_RUNNING : S_START;
            end

            S_RUNNING: begin
                // Collision outranks level-up; a simultaneous level-up is dropped.
                if (i_Has_Collided) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = S_OVER;
                        timer_d = OVER_LOAD;
                    end else begin
                        state_d = S_HIT;
                        timer_d = HIT_LOAD;
                    end
                end else if (i_Level_Up) begin
                    state_d = S_LEVEL;
                    timer_d = LEVEL_LOAD;
                    if (level_q < MAX_LEVEL) begin
                        level_d = level_q + 4'd1;
                    end
                end else begin
                    state_d = S_RUNNING;
                end
            end

            S_HIT: begin
                state_d = expired ? S_RUNNING : S_HIT;
            end

            S_LEVEL: begin
                state_d = expired ? S_RUNNING : S_LEVEL;
            end

            S_OVER: begin
                // Requiring i_Start low after the hold stops a held switch
                // from immediately starting another game.
                if (expired && !i_Start) begin
                    state_d = S_IDLE;
                    lives_d = LIVES_INI;
                    level_d = 4'd1;
                end else begin
                    state_d = S_OVER;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = 26'd0;
                lives_d = LIVES_INI;
                level_d = 4'd1;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= S_IDLE;
            timer_q       <= 26'd0;
            lives_q       <= LIVES_INI;
            level_q       <= 4'd1;
            game_active_q <= 1'b0;
            freeze_q      <= 1'b0;
            frog_reset_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            // Flag outputs are decoded from the next state so they line up
            // with the state register rather than lagging it by a cycle.
            game_active_q <= (state_d == S_RUNNING);
            freeze_q      <= (state_d == S_START) || (state_d == S_HIT) ||
                             (state_d == S_LEVEL) || (state_d == S_OVER);
            frog_reset_q  <= (state_d != state_t'(state_q)) &&
                             ((state_d == S_START) || (state_d == S_HIT) ||
                              (state_d == S_LEVEL));
            game_over_q   <= (state_d == S_OVER);
        end
    end

    assign o_Game_Active = game_active_q;
    assign o_Freeze      = freeze_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Game_Over   = game_over_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus random play,
// compared every cycle against a cycle-count based behavioural model.
// Inputs change just after the falling edge; outputs are compared on the falling edge.
module tb_game_sequencer;

    localparam int P_START = 4;
    localparam int P_HIT   = 3;
    localparam int P_LEVEL = 2;
    localparam int P_OVER  = 5;
    localparam int P_LIVES = 3;
    localparam int P_MAXLV = 9;

    localparam int IDLE = 0, START = 1, RUN = 2, HIT = 3, LEVEL = 4, OVER = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       coll  = 1'b0;
    logic       lvl   = 1'b0;
    logic       game_active, freeze, frog_reset, game_over;
    logic [1:0] lives;
    logic [3:0] level;
    logic [2:0] st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .c_LIVES_INI  (P_LIVES),
        .c_MAX_LEVEL  (P_MAXLV),
        .c_START_DELAY(P_START),
        .c_HIT_FREEZE (P_HIT),
        .c_LEVEL_PAUSE(P_LEVEL),
        .c_OVER_HOLD  (P_OVER)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Start       (start),
        .i_Has_Collided(coll),
        .i_Level_Up    (lvl),
        .o_Game_Active (game_active),
        .o_Freeze      (freeze),
        .o_Frog_Reset  (frog_reset),
        .o_Lives       (lives),
        .o_Level       (level),
        .o_Game_Over   (game_over),
        .o_State       (st)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the state name and how many cycles it has been occupied;
    // timed states leave after their dwell count is reached.
    int m_state = IDLE;
    int m_lives = P_LIVES;
    int m_level = 1;
    int m_cnt   = 1;
    bit m_frog  = 1'b0;
    int inject_req = 0;
    int inject_ack = 0;

    always @(posedge clk or negedge rst_n) begin
        int ns;
        if (!rst_n) begin
            m_state = IDLE; m_lives = P_LIVES; m_level = 1; m_cnt = 1; m_frog = 1'b0;
        end else if (inject_req != inject_ack) begin
            // state register was corrupted to an unused encoding
            inject_ack = inject_req;
            m_state = IDLE; m_lives = P_LIVES; m_level = 1; m_cnt = 1; m_frog = 1'b0;
        end else begin
            ns = m_state;
            case (m_state)
                IDLE:  if (start) ns = START;
                START: if (m_cnt >= P_START) ns = RUN;
                RUN: begin
                    if (coll) begin
                        ns = (m_lives == 1) ? OVER : HIT;
                        m_lives = m_lives - 1;
                    end else if (lvl) begin
                        ns = LEVEL;
                        m_level = (m_level + 1 > P_MAXLV) ? P_MAXLV : m_level + 1;
                    end
                end
                HIT:   if (m_cnt >= P_HIT) ns = RUN;
                LEVEL: if (m_cnt >= P_LEVEL) ns = RUN;
                OVER: begin
                    if (m_cnt >= P_OVER && !start) begin
                        ns = IDLE; m_lives = P_LIVES; m_level = 1;
                    end
                end
                default: ns = IDLE;
            endcase
            m_frog  = (ns != m_state) && (ns == START || ns == HIT || ns == LEVEL);
            m_cnt   = (ns != m_state) ? 1 : m_cnt + 1;
            m_state = ns;
        end
    end

    always @(negedge clk) begin
        check("state",       int'(st),          m_state);
        check("game_active", int'(game_active), int'(m_state == RUN));
        check("freeze",      int'(freeze),      int'(m_state == START || m_state == HIT ||
                                                     m_state == LEVEL || m_state == OVER));
        check("frog_reset",  int'(frog_reset),  int'(m_frog));
        check("lives",       int'(lives),       m_lives);
        check("level",       int'(level),       m_level);
        check("game_over",   int'(game_over),   int'(m_state == OVER));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic s, input logic c, input logic l);
        @(negedge clk);
        #1;
        start = s; coll = c; lvl = l;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_game();
        cyc(1'b1, 1'b0, 1'b0);
        settle();
        check("lit_start_state", int'(st), START);
        check("lit_start_frog",  int'(frog_reset), 1);
        check("lit_start_freeze", int'(freeze), 1);
        repeat (P_START) cyc(1'b0, 1'b0, 1'b0);
        settle();
        check("lit_run_state",  int'(st), RUN);
        check("lit_run_active", int'(game_active), 1);
        check("lit_run_freeze", int'(freeze), 0);
    endtask

    initial begin
        // ---- reset values ----
        repeat (3) @(negedge clk);
        #2;
        check("lit_rst_state", int'(st), IDLE);
        check("lit_rst_lives", int'(lives), P_LIVES);
        check("lit_rst_level", int'(level), 1);
        rst_n = 1'b1;

        // ---- start countdown, then collision with held collide input ----
        begin_game();
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        check("lit_hit_state",  int'(st), HIT);
        check("lit_hit_lives",  int'(lives), 2);
        check("lit_hit_frog",   int'(frog_reset), 1);
        check("lit_hit_active", int'(game_active), 0);
        repeat (P_HIT) cyc(1'b0, 1'b1, 1'b0);
        settle();
        check("lit_hit_return", int'(st), RUN);
        check("lit_hit_held_lives", int'(lives), 2);

        // ---- async reset while in HIT ----
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        check("lit_hit2_state", int'(st), HIT);
        @(negedge clk);
        #1;
        coll = 1'b0;
        rst_n = 1'b0;
        #1;
        check("lit_arst_state",  int'(st), IDLE);
        check("lit_arst_lives",  int'(lives), P_LIVES);
        check("lit_arst_freeze", int'(freeze), 0);
        check("lit_arst_frog",   int'(frog_reset), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // ---- level climb and saturation ----
        begin_game();
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            settle();
            check("lit_level_state", int'(st), LEVEL);
            check("lit_level_value", int'(level), (i + 1 > P_MAXLV) ? P_MAXLV : i + 1);
            repeat (P_LEVEL) cyc(1'b0, 1'b0, 1'b0);
        end
        settle();
        check("lit_level_return", int'(st), RUN);

        // ---- collision and level-up together ----
        cyc(1'b0, 1'b1, 1'b1);
        settle();
        check("lit_simul_state", int'(st), HIT);
        check("lit_simul_lives", int'(lives), 2);
        check("lit_simul_level", int'(level), P_MAXLV);
        repeat (P_HIT) cyc(1'b0, 1'b0, 1'b0);

        // ---- game over, held start must not restart ----
        cyc(1'b0, 1'b1, 1'b0);
        repeat (P_HIT) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        settle();
        check("lit_over_state", int'(st), OVER);
        check("lit_over_flag",  int'(game_over), 1);
        check("lit_over_lives", int'(lives), 0);
        check("lit_over_frog",  int'(frog_reset), 0);
        repeat (12) cyc(1'b1, 1'b0, 1'b0);
        settle();
        check("lit_over_hold", int'(st), OVER);
        cyc(1'b0, 1'b0, 1'b0);
        settle();
        check("lit_over_exit",  int'(st), IDLE);
        check("lit_over_lives_ini", int'(lives), P_LIVES);
        check("lit_over_level_ini", int'(level), 1);

        // ---- unused state encoding recovers to IDLE ----
        begin_game();
        @(negedge clk);
        #1;
        inject_req++;
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        settle();
        check("lit_illegal_state", int'(st), IDLE);

        // ---- random play ----
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk);
                #1;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0));
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
